// File: rtl/fx2_slave_fifo_model_pkg.sv
// Shared FX2LP slave-FIFO constants: endpoint addresses, flag polarity, FD bus width.
package fx2_pkg;

  localparam int FX2_FD_WIDTH = 16;

  localparam logic [1:0] FX2_EP2 = 2'b00;
  localparam logic [1:0] FX2_EP4 = 2'b01;
  localparam logic [1:0] FX2_EP6 = 2'b10;
  localparam logic [1:0] FX2_EP8 = 2'b11;

  // Flags are high when the condition they name (not-empty / not-full) holds.
  localparam logic FX2_FLAG_ACTIVE = 1'b1;

endpackage

// File: rtl/fx2_slave_fifo_model_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push and pop take effect on the clock edge.
// A pop from a non-empty FIFO frees a slot for a push in the same cycle, even when full.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/fx2_slave_fifo_model.sv
// FX2LP slave-FIFO responder: EP2 (host -> FD) and EP6 (FD -> host) FIFOs behind the SL* strobes.
// Optional EP4 OUT FIFO at fifoaddr 01 when FX2_MODEL_EP4_EN is defined.
module fx2_slave_fifo_model
  import fx2_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = FX2_FD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   usb_slcs,
  input  logic                   usb_slrd,
  input  logic                   usb_slwr,
  input  logic                   usb_sloe,
  input  logic [1:0]             usb_fifoaddr,
  inout  wire  [WIDTH-1:0]       usb_fd,
  output logic                   usb_flaga,
  output logic                   usb_flagb,
  output logic                   usb_flagc,
  input  logic                   host_wr_valid,
  input  logic [WIDTH-1:0]       host_wr_data,
  output logic                   host_wr_ready,
`ifdef FX2_MODEL_EP4_EN
  input  logic                   host_wr_ep4,
`endif
  output logic                   host_rd_valid,
  output logic [WIDTH-1:0]       host_rd_data,
  input  logic                   host_rd_ready,
  output logic [$clog2(DEPTH):0] ep2_count,
  output logic [$clog2(DEPTH):0] ep6_count,
  output logic                   err_underflow,
  output logic                   err_overflow
);

  logic             slrd_q, slwr_q, err_underflow_q, err_overflow_q;
  logic             rd_edge, wr_edge, underflow_d, overflow_d;
  logic             ep2_push, ep2_pop, ep2_full, ep2_empty;
  logic             ep6_push, ep6_pop, ep6_full, ep6_empty;
  logic             ep4_empty, wr_to_ep4, fd_drive;
  logic [WIDTH-1:0] ep2_head, ep4_head, fd_out;

  assign rd_edge = ~slrd_q & usb_slrd & ~usb_slcs;
  assign wr_edge = ~slwr_q & usb_slwr & ~usb_slcs;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ep2 (
    .clk(clk), .reset(reset), .push(ep2_push), .pop(ep2_pop), .din(host_wr_data),
    .head(ep2_head), .full(ep2_full), .empty(ep2_empty), .count(ep2_count)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ep6 (
    .clk(clk), .reset(reset), .push(ep6_push), .pop(ep6_pop), .din(usb_fd),
    .head(host_rd_data), .full(ep6_full), .empty(ep6_empty), .count(ep6_count)
  );

`ifdef FX2_MODEL_EP4_EN
  logic                   ep4_push, ep4_pop, ep4_full;
  logic [$clog2(DEPTH):0] ep4_count;

  assign wr_to_ep4     = host_wr_ep4;
  assign ep4_push      = host_wr_valid & host_wr_ready & wr_to_ep4;
  assign ep4_pop       = rd_edge & (usb_fifoaddr == FX2_EP4);
  assign host_wr_ready = wr_to_ep4 ? ~ep4_full : ~ep2_full;
  assign usb_flagb     = (ep4_count != '0) ? FX2_FLAG_ACTIVE : ~FX2_FLAG_ACTIVE;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ep4 (
    .clk(clk), .reset(reset), .push(ep4_push), .pop(ep4_pop), .din(host_wr_data),
    .head(ep4_head), .full(ep4_full), .empty(ep4_empty), .count(ep4_count)
  );
`else
  // Without EP4 storage, address 01 behaves as a permanently empty OUT endpoint.
  assign wr_to_ep4     = 1'b0;
  assign ep4_empty     = 1'b1;
  assign ep4_head      = '0;
  assign host_wr_ready = ~ep2_full;
  assign usb_flagb     = 1'b0;
`endif

  assign ep2_push = host_wr_valid & host_wr_ready & ~wr_to_ep4;
  assign ep2_pop  = rd_edge & (usb_fifoaddr == FX2_EP2);
  assign ep6_push = wr_edge & (usb_fifoaddr == FX2_EP6);
  assign ep6_pop  = host_rd_valid & host_rd_ready;

  assign host_rd_valid = ~ep6_empty;
  assign usb_flaga     = ep2_empty ? ~FX2_FLAG_ACTIVE : FX2_FLAG_ACTIVE;
  assign usb_flagc     = ep6_full  ? ~FX2_FLAG_ACTIVE : FX2_FLAG_ACTIVE;

  assign underflow_d = rd_edge & (((usb_fifoaddr == FX2_EP2) & ep2_empty) |
                                  ((usb_fifoaddr == FX2_EP4) & ep4_empty));
  // A host pop in the same cycle makes room, so a write to a full EP6 is not lost then.
  assign overflow_d  = ep6_push & ep6_full & ~ep6_pop;

  always_comb begin
    fd_out = '0;
    case (usb_fifoaddr)
      FX2_EP2: fd_out = ep2_empty ? '0 : ep2_head;
      FX2_EP4: fd_out = ep4_empty ? '0 : ep4_head;
      default: fd_out = '0;
    endcase
  end

  assign fd_drive = ~usb_slcs & ~usb_sloe & ~usb_fifoaddr[1];
  assign usb_fd   = fd_drive ? fd_out : {WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      slrd_q          <= 1'b1;
      slwr_q          <= 1'b1;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      slrd_q <= usb_slrd;
      slwr_q <= usb_slwr;
      if (underflow_d) err_underflow_q <= 1'b1;
      if (overflow_d)  err_overflow_q  <= 1'b1;
    end
  end

  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Directed bench for fx2_slave_fifo_model: host/USB transfers, full/empty edges, errors, reset.
module tb_fx2_slave_fifo_model;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        usb_slcs = 1'b1, usb_slrd = 1'b1, usb_slwr = 1'b1, usb_sloe = 1'b1;
  logic [1:0]  usb_fifoaddr = 2'b00;
  wire  [15:0] usb_fd;
  logic [15:0] tb_fd = 16'h0000;
  logic        tb_fd_en = 1'b0;
  logic        usb_flaga, usb_flagb, usb_flagc;
  logic        host_wr_valid = 1'b0;
  logic [15:0] host_wr_data = 16'h0000;
  logic        host_wr_ready;
  logic        host_rd_valid;
  logic [15:0] host_rd_data;
  logic        host_rd_ready = 1'b0;
  logic [4:0]  ep2_count, ep6_count;
  logic        err_underflow, err_overflow;
`ifdef FX2_MODEL_EP4_EN
  logic        host_wr_ep4 = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  assign usb_fd = tb_fd_en ? tb_fd : 16'hzzzz;

  always #10 clk = ~clk;

  fx2_slave_fifo_model #(.DEPTH(16), .WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .usb_slcs(usb_slcs), .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_sloe(usb_sloe),
    .usb_fifoaddr(usb_fifoaddr), .usb_fd(usb_fd),
    .usb_flaga(usb_flaga), .usb_flagb(usb_flagb), .usb_flagc(usb_flagc),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
`ifdef FX2_MODEL_EP4_EN
    .host_wr_ep4(host_wr_ep4),
`endif
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .host_rd_ready(host_rd_ready),
    .ep2_count(ep2_count), .ep6_count(ep6_count),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 ns after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd_pulse(input int low_cycles);
    usb_slrd = 1'b0;
    repeat (low_cycles) step();
    usb_slrd = 1'b1;
    step();
  endtask

  task automatic usb_write(input logic [15:0] val, input int low_cycles);
    tb_fd    = val;
    tb_fd_en = 1'b1;
    usb_slwr = 1'b0;
    repeat (low_cycles) step();
    usb_slwr = 1'b1;
    step();
  endtask

  task automatic host_push(input logic [15:0] val);
    host_wr_valid = 1'b1;
    host_wr_data  = val;
    step();
    host_wr_valid = 1'b0;
  endtask

  initial begin
    // Reset, with the bench holding a pattern on FD to show the DUT is not driving.
    tb_fd = 16'hC3C3;
    tb_fd_en = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_flaga", 32'(usb_flaga), 32'h0);
    check("rst_flagb", 32'(usb_flagb), 32'h0);
    check("rst_flagc", 32'(usb_flagc), 32'h1);
    check("rst_fd_released", 32'(usb_fd), 32'hC3C3);
    check("rst_ep2_count", 32'(ep2_count), 32'h0);
    check("rst_ep6_count", 32'(ep6_count), 32'h0);
    check("rst_errs", {30'h0, err_underflow, err_overflow}, 32'h0);
    check("rst_wr_ready", 32'(host_wr_ready), 32'h1);
    check("rst_rd_valid", 32'(host_rd_valid), 32'h0);
    tb_fd_en = 1'b0;

    // Host fills EP2, USB side pops with long strobes.
    host_push(16'h1234);
    check("flaga_after_push", 32'(usb_flaga), 32'h1);
    host_push(16'hABCD);
    usb_slcs = 1'b0;
    usb_sloe = 1'b0;
    usb_fifoaddr = 2'b00;
    #1;
    check("ep2_count_2", 32'(ep2_count), 32'h2);
    check("fd_head_1234", 32'(usb_fd), 32'h1234);
    rd_pulse(9);
    check("fd_head_abcd", 32'(usb_fd), 32'hABCD);
    check("ep2_count_1", 32'(ep2_count), 32'h1);
    rd_pulse(1);
    check("flaga_drained", 32'(usb_flaga), 32'h0);
    check("fd_empty_zero", 32'(usb_fd), 32'h0);
    check("no_underflow_yet", 32'(err_underflow), 32'h0);

    // USB write into EP6, host drains it.
    usb_sloe = 1'b1;
    usb_fifoaddr = 2'b10;
    usb_write(16'h5A5A, 9);
    check("rd_valid_5a5a", 32'(host_rd_valid), 32'h1);
    check("rd_data_5a5a", 32'(host_rd_data), 32'h5A5A);
    check("ep6_count_1", 32'(ep6_count), 32'h1);
    host_rd_ready = 1'b1;
    step();
    host_rd_ready = 1'b0;
    check("ep6_drained", 32'(host_rd_valid), 32'h0);

    // Fill EP6 to the brim, then overflow.
    for (int i = 0; i < 16; i++) usb_write(16'(i), 1);
    check("flagc_full", 32'(usb_flagc), 32'h0);
    check("ep6_count_16", 32'(ep6_count), 32'h10);
    check("no_overflow_yet", 32'(err_overflow), 32'h0);
    usb_write(16'hFFFF, 1);
    check("overflow_set", 32'(err_overflow), 32'h1);
    check("ep6_count_still_16", 32'(ep6_count), 32'h10);
    tb_fd_en = 1'b0;
    host_rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), {15'h0, host_rd_valid, host_rd_data}, {16'h1, 16'(i)});
      step();
    end
    host_rd_ready = 1'b0;
    check("ep6_empty_after_drain", 32'(host_rd_valid), 32'h0);
    check("flagc_space", 32'(usb_flagc), 32'h1);

    // Underflow on empty EP2.
    usb_fifoaddr = 2'b00;
    usb_sloe = 1'b0;
    rd_pulse(2);
    check("underflow_set", 32'(err_underflow), 32'h1);
    check("underflow_fd_zero", 32'(usb_fd), 32'h0);
    check("underflow_count_0", 32'(ep2_count), 32'h0);

    // Simultaneous host push and USB pop with one word held.
    host_push(16'h1111);
    usb_slrd = 1'b0;
    step();
    usb_slrd = 1'b1;
    host_push(16'h2222);
    check("simul_count_1", 32'(ep2_count), 32'h1);
    check("simul_flaga", 32'(usb_flaga), 32'h1);
    check("simul_head", 32'(usb_fd), 32'h2222);

    // Deselected chip ignores strobes; EP4 address reads as empty.
    usb_slcs = 1'b1;
    rd_pulse(1);
    check("slcs_high_no_pop", 32'(ep2_count), 32'h1);
    usb_slcs = 1'b0;
    usb_fifoaddr = 2'b01;
    #1;
    check("ep4_fd_zero", 32'(usb_fd), 32'h0);
    check("ep4_flagb", 32'(usb_flagb), 32'h0);

    // Reset while SLRD is low; SLRD rises as reset releases and must not make an edge.
    usb_fifoaddr = 2'b00;
    usb_slrd = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    usb_slrd = 1'b1;
    step();
    step();
    check("post_rst_no_edge", 32'(err_underflow), 32'h0);
    check("post_rst_flushed", 32'(ep2_count), 32'h0);
    check("post_rst_overflow_clr", 32'(err_overflow), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fx2_slave_fifo_model.md
# fx2_slave_fifo_model

Responder side of the FX2LP slave-FIFO interface: a synthesizable model of the CY68013 endpoint FIFOs that the FPGA-side FIFO master talks to. Exposes the same pin set the master drives (SLCS/SLRD/SLWR/SLOE/FIFOADR/FD/FLAGA–C) and a host-side stream port that fills the OUT endpoint (EP2) and drains the IN endpoint (EP6). Used for board-less loopback on the AX530 and as the bus target in simulation benches.

## Interface
- DEPTH, 16, words per endpoint FIFO; power of two, at least 2
- WIDTH, 16, FD bus width; fixed at 16 for FX2LP 16-bit mode
- clk  in  1  system clock, 50 MHz; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- usb_slcs  in  1  chip select, active low
- usb_slrd  in  1  read strobe, active low; pop on rising edge
- usb_slwr  in  1  write strobe, active low; push on rising edge
- usb_sloe  in  1  output enable, active low
- usb_fifoaddr  in  2  endpoint select: 00 EP2, 01 EP4, 10 EP6, 11 EP8
- usb_fd  inout  16  FIFO data bus
- usb_flaga  out  1  EP2 not-empty (1 = data available)
- usb_flagb  out  1  EP4 not-empty
- usb_flagc  out  1  EP6 not-full (1 = space available)
- host_wr_valid / host_wr_data[15:0] / host_wr_ready  in/in/out  push into EP2, valid/ready
- host_rd_valid / host_rd_data[15:0] / host_rd_ready  out/out/in  pop from EP6, valid/ready, FWFT
- ep2_count, ep6_count  out  $clog2(DEPTH)+1  current fill levels
- err_underflow, err_overflow  out  1  sticky error flags

## Operation
- Reset: all FIFOs empty, pointers 0; usb_flaga=0, usb_flagb=0, usb_flagc=1; host_wr_ready=1, host_rd_valid=0; counts 0; errors 0; usb_fd high-Z.
- Strobe detect: usb_slrd and usb_slwr registered each cycle (slrd_q, slwr_q, reset to 1). Rising edge = q==0 && pin==1 && usb_slcs==0.
- Read: on SLRD rising edge with fifoaddr 00 (or 01 when EP4 enabled), pop that FIFO if non-empty; if empty, no pointer change, err_underflow<=1. Reads at 10/11 are ignored.
- Write: on SLWR rising edge with fifoaddr 10, push usb_fd into EP6 if not full; if full, word is dropped, err_overflow<=1. Writes at 00/01/11 are ignored.
- Drive: usb_fd = head word of selected OUT FIFO when usb_slcs==0 && usb_sloe==0 && fifoaddr is an OUT endpoint; 16'h0000 if that FIFO is empty; otherwise high-Z. FWFT: head is valid without a strobe.
- Host push: host_wr_valid && host_wr_ready pushes to EP2; host_wr_ready = ~EP2 full.
- Host pop: host_rd_valid = ~EP6 empty; host_rd_data = EP6 head; pop on host_rd_valid && host_rd_ready.
- Simultaneous push and pop on one FIFO in one cycle: both happen, count unchanged; allowed even when full (pop frees the slot) or empty for host push + USB pop only when count>=1.
- Errors are sticky until reset.

## Timing
- Strobe-to-pointer latency: edge detected in the cycle the pin is seen high; pointer/count update at that clock edge.
- Flags and counts are registered: reflect post-update fill level from the following cycle.
- usb_fd head change visible the cycle after the pop edge.
- Host push to usb_flaga=1: 1 cycle. USB write edge to host_rd_valid=1: 1 cycle.
- Strobes held low any number of cycles produce exactly one pop/push per low-high transition.
- Reset mid-transfer: FIFOs flushed, strobe registers forced to 1 so a strobe still high after reset generates no edge.

## Configuration
- FX2_MODEL_EP4_EN defined: second OUT FIFO (EP4, depth DEPTH) at fifoaddr 01, reported on usb_flagb, filled via host_wr port when host_wr_ep4 (extra 1-bit input) is 1.
- Undefined: no EP4 storage; usb_flagb tied 0; fifoaddr 01 treated as empty OUT endpoint (drives 16'h0000, read edge sets err_underflow); host_wr_ep4 port absent.

## Structure
- Package fx2_pkg: FIFOADR constants (FX2_EP2=2'b00, FX2_EP4=2'b01, FX2_EP6=2'b10, FX2_EP8=2'b11), flag polarity constants, FD width.
- Sub-module sync_fifo (WIDTH, DEPTH; FWFT head, push, pop, full, empty, count, synchronous active-high reset), instantiated for EP2, EP6 and optional EP4. Top module holds strobe detect, address decode, tri-state and error logic.

## Test plan
- Reset asserted 3 cycles -> usb_flaga=0, usb_flagb=0, usb_flagc=1, usb_fd=Z, counts 0, errors 0.
- Host pushes 0x1234, 0xABCD; slcs=0, sloe=0, addr=00 -> usb_fd=0x1234; slrd low 9 cycles then high -> usb_fd=0xABCD next cycle, ep2_count=1; second pop -> usb_flaga=0.
- addr=10, fd=0x5A5A, slwr low 9 cycles then high -> next cycle host_rd_valid=1, host_rd_data=0x5A5A, ep6_count=1.
- 16 USB writes 0x0000..0x000F with host_rd_ready=0 -> usb_flagc=0; 17th write (0xFFFF) dropped, err_overflow=1; drain returns 0x0000..0x000F in order.
- SLRD edge at addr=00 with EP2 empty -> err_underflow=1, usb_fd=0x0000, ep2_count stays 0.
- ep2_count=1, host push and USB pop edge in same cycle -> ep2_count stays 1, usb_flaga stays 1, head = pushed word.
